rgb_seq_ctrl: RTL and testbench

RGB_SEQ_CTRL -- requirements
Module: rgb_seq_ctrl

---
 rtl/rgb_seq_ctrl_pkg.sv | 24 ++
 rtl/rgb_seq_ctrl_btn_debounce.sv | 72 +++++++
 rtl/rgb_seq_ctrl.sv | 140 ++++++++++++++
 tb/tb_rgb_seq_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/rgb_seq_ctrl_pkg.sv
// Shared definitions for the RGB sequencer: FSM state encoding, PWM
// constants, button index map and the auto-step period shift helper.
package rgb_seq_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_MANUAL = 2'd0,
      ST_AUTO   = 2'd1,
      ST_PAUSE  = 2'd2
   } state_t;

   localparam int PWM_W        = 8;
   localparam int PWM_DIM_DUTY = 64;

   localparam int BTN_STEP  = 0;
   localparam int BTN_PAUSE = 1;
   localparam int BTN_SPEED = 2;
   localparam int BTN_CLEAR = 3;

   // Speed 0 is the slowest setting (8x base period), speed 3 the fastest (1x).
   function automatic logic [1:0] period_shift(input logic [1:0] speed);
      return 2'd3 - speed;
   endfunction

endpackage

// File: rtl/rgb_seq_ctrl_btn_debounce.sv
// Single-button debouncer. The input must already be synchronized.
// The level follows din only after DEB_CYC consecutive differing samples.
// A one-cycle registered pulse marks each accepted rising edge, but only
// once the button has been seen released after reset. This keeps a
// button that is held through reset from producing a spurious press.
import rgb_seq_ctrl_pkg::*;

module btn_debounce #(
   parameter int DEB_CYC = 1_250_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic level,
   output logic rise
);

   // Arming needs two extra samples so the zeros flushed out of the
   // synchronizer right after reset can never arm a held button.
   localparam int ARM_CYC = DEB_CYC + 2;
   localparam int CNT_W   = $clog2(ARM_CYC + 1);

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] arm_cnt;
   logic             armed;
   logic             level_d;

   // Accept a new level after DEB_CYC consecutive samples that disagree with it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt   <= '0;
         level <= 1'b0;
      end else if (din != level) begin
         if (cnt == CNT_W'(DEB_CYC - 1)) begin
            level <= din;
            cnt   <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end else begin
         cnt <= '0;
      end
   end

   // Arm the pulse output once the button has been seen stably released.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         armed   <= 1'b0;
         arm_cnt <= '0;
      end else if (!armed) begin
         if (din) begin
            arm_cnt <= '0;
         end else if (arm_cnt == CNT_W'(ARM_CYC - 1)) begin
            armed <= 1'b1;
         end else begin
            arm_cnt <= arm_cnt + 1'b1;
         end
      end
   end

   // Registered one-cycle pulse on each accepted rising level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         level_d <= 1'b0;
         rise    <= 1'b0;
      end else begin
         level_d <= level;
         rise    <= level & ~level_d & armed;
      end
   end

endmodule

// File: rtl/rgb_seq_ctrl.sv
// RGB colour sequencer. Buttons step, pause, change speed and clear a
// 3-bit colour code, either manually or on an auto-step timer. A PWM gate
// optionally dims the output to 25% duty.
import rgb_seq_ctrl_pkg::*;

module rgb_seq_ctrl #(
   parameter int CLK_HZ   = 125_000_000,
   parameter int DEB_CYC  = CLK_HZ / 100,
   parameter int STEP_CYC = CLK_HZ / 40
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] sw,
   input  logic [3:0] btn,
   output logic [2:0] rgb_code,
   output logic       rgb_en,
   output logic [1:0] state
);

   localparam int                TICK_W = $clog2(8 * STEP_CYC + 1);
   localparam logic [TICK_W-1:0] STEP_V = TICK_W'(STEP_CYC);

   logic [1:0]        sw_p0, sw_p1;
   logic [3:0]        btn_p0, btn_p1;
   logic [3:0]        btn_lvl, btn_rise, btn_pulse;
   logic [1:0]        speed;
   logic [TICK_W-1:0] tick_cnt;
   logic [TICK_W-1:0] period_m1;
   logic [PWM_W-1:0]  pwm_cnt;
   logic [2:0]        code_r;
   state_t            state_r;
   logic              mode, dim;

   // Two-flop synchronizers for every asynchronous switch and button input.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sw_p0  <= '0;
         sw_p1  <= '0;
         btn_p0 <= '0;
         btn_p1 <= '0;
      end else begin
         sw_p0  <= sw;
         sw_p1  <= sw_p0;
         btn_p0 <= btn;
         btn_p1 <= btn_p0;
      end
   end

   for (genvar i = 0; i < 4; i++) begin : g_deb
      btn_debounce #(.DEB_CYC(DEB_CYC)) u_deb (
         .clk   (clk),
         .rst_n (rst_n),
         .din   (btn_p1[i]),
         .level (btn_lvl[i]),
         .rise  (btn_rise[i])
      );
   end

   // A press pulse is only honoured while the debounced button is still down.
   assign btn_pulse = btn_rise & btn_lvl;
   assign mode      = sw_p1[0];
   assign dim       = sw_p1[1];
   assign period_m1 = (STEP_V << period_shift(speed)) - 1'b1;

   // Speed selector cycles 0..3 on each speed press, in every state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         speed <= 2'd0;
      end else if (btn_pulse[BTN_SPEED]) begin
         speed <= speed + 2'd1;
      end
   end

   // Mode FSM with colour code and auto-step tick counter; clear overrides last.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r  <= ST_MANUAL;
         code_r   <= 3'd0;
         tick_cnt <= '0;
      end else begin
         case (state_r)
            ST_MANUAL: begin
               tick_cnt <= '0;
               if (mode) begin
                  state_r <= ST_AUTO;
               end else if (btn_pulse[BTN_STEP]) begin
                  code_r <= code_r + 3'd1;
               end
            end
            ST_AUTO: begin
               if (!mode) begin
                  state_r  <= ST_MANUAL;
                  tick_cnt <= '0;
               end else if (btn_pulse[BTN_PAUSE]) begin
                  state_r <= ST_PAUSE;
               end else if (tick_cnt >= period_m1) begin
                  code_r   <= code_r + 3'd1;
                  tick_cnt <= '0;
               end else begin
                  tick_cnt <= tick_cnt + 1'b1;
               end
            end
            ST_PAUSE: begin
               // Resuming keeps the frozen count so the remaining period is honoured.
               if (!mode) begin
                  state_r  <= ST_MANUAL;
                  tick_cnt <= '0;
               end else if (btn_pulse[BTN_PAUSE]) begin
                  state_r <= ST_AUTO;
               end else if (btn_pulse[BTN_STEP]) begin
                  code_r <= code_r + 3'd1;
               end
            end
            default: begin
               state_r  <= ST_MANUAL;
               tick_cnt <= '0;
            end
         endcase
         if (btn_pulse[BTN_CLEAR]) begin
            code_r   <= 3'd0;
            tick_cnt <= '0;
         end
      end
   end

   // Free-running PWM counter and registered dimming gate.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pwm_cnt <= '0;
         rgb_en  <= 1'b1;
      end else begin
         pwm_cnt <= pwm_cnt + 1'b1;
         rgb_en  <= ~dim | (pwm_cnt < PWM_W'(PWM_DIM_DUTY));
      end
   end

   assign rgb_code = code_r;
   assign state    = state_r;

endmodule

// File: tb/tb_rgb_seq_ctrl.sv
// Directed bench for rgb_seq_ctrl with DEB_CYC=4, STEP_CYC=16.
module tb_rgb_seq_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [1:0] sw;
   logic [3:0] btn;
   logic [2:0] rgb_code;
   logic       rgb_en;
   logic [1:0] state;

   int n_tot = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   rgb_seq_ctrl #(.DEB_CYC(4), .STEP_CYC(16)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .sw       (sw),
      .btn      (btn),
      .rgb_code (rgb_code),
      .rgb_en   (rgb_en),
      .state    (state)
   );

   task automatic chk(input string tag, input int obs, input int exp);
      n_tot++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0d want=%0d", tag, obs, exp);
      end
   endtask

   // Advance n rising edges, then settle 1 time unit past the edge.
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic press(input logic [3:0] b);
      btn = b;
      step(10);
      btn = 4'b0000;
      step(12);
   endtask

   // Press and check the code is unchanged after 7 cycles and updated after 8.
   task automatic press_lat(input logic [3:0] b, input int old_c, input int new_c);
      btn = b;
      step(7);
      chk("lat_before", rgb_code, old_c);
      step(1);
      chk("lat_after", rgb_code, new_c);
      step(2);
      btn = 4'b0000;
      step(12);
   endtask

   task automatic wait_change(input int limit, output int n);
      logic [2:0] c0;
      c0 = rgb_code;
      n  = 0;
      do begin
         step(1);
         n++;
      end while (rgb_code == c0 && n < limit);
      if (rgb_code == c0) chk("change_timeout", n, limit + 1);
   endtask

   task automatic count_en(output int n);
      n = 0;
      repeat (256) begin
         step(1);
         n += int'(rgb_en);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int c;
      int exp_c;
      rst_n = 1'b0;
      sw    = 2'b00;
      btn   = 4'b0000;
      step(3);
      chk("rst_code", rgb_code, 0);
      chk("rst_en", rgb_en, 1);
      chk("rst_state", state, 0);
      rst_n = 1'b1;
      step(10);

      // Manual stepping with exact latency
      press_lat(4'b0001, 0, 1);
      press_lat(4'b0001, 1, 2);
      press_lat(4'b0001, 2, 3);

      // 3-cycle glitch is rejected
      btn = 4'b0001;
      step(3);
      btn = 4'b0000;
      step(20);
      chk("glitch", rgb_code, 3);

      // Eight presses, wrapping 7 -> 0 along the way
      exp_c = 3;
      for (int i = 0; i < 8; i++) begin
         press_lat(4'b0001, exp_c, (exp_c + 1) % 8);
         exp_c = (exp_c + 1) % 8;
      end

      // Auto mode at speed 0: 128-cycle period
      sw = 2'b01;
      wait_change(300, n);
      chk("auto_first", n, 131);
      chk("auto_state", state, 1);
      wait_change(300, n);
      chk("auto_p0", n, 128);

      // Step is ignored in AUTO
      c = rgb_code;
      btn = 4'b0001;
      step(9);
      chk("auto_step_ign", rgb_code, c);
      btn = 4'b0000;
      step(12);

      // Three speed presses -> 16-cycle period
      press(4'b0100);
      press(4'b0100);
      press(4'b0100);
      wait_change(300, n);
      wait_change(100, n);
      chk("auto_p3", n, 16);

      // Pause freezes code; step works in PAUSE; resume honours remaining period
      press(4'b0010);
      chk("pause_state", state, 2);
      c = rgb_code;
      step(500);
      chk("pause_hold", rgb_code, c);
      chk("pause_state2", state, 2);
      press_lat(4'b0001, c, (c + 1) % 8);
      btn = 4'b0010;
      wait_change(100, n);
      chk("resume_rem", n, 17);
      btn = 4'b0000;
      step(12);
      chk("resume_state", state, 1);

      // Back to manual; clear beats a coincident step
      sw = 2'b00;
      step(5);
      chk("manual_state", state, 0);
      press(4'b1000);
      chk("clear", rgb_code, 0);
      press(4'b0001);
      chk("step_after_clr", rgb_code, 1);
      press(4'b1001);
      chk("clr_vs_step", rgb_code, 0);

      // Clear coincides with an AUTO tick, and restarts the period
      sw = 2'b01;
      step(11);
      btn = 4'b1000;
      step(8);
      chk("tick_vs_clr", rgb_code, 0);
      chk("tick_clr_state", state, 1);
      btn = 4'b0000;
      wait_change(100, n);
      chk("after_clr", n, 16);

      // PWM dimming duty
      sw = 2'b10;
      step(5);
      count_en(n);
      chk("pwm_dim", n, 64);
      sw = 2'b00;
      step(5);
      count_en(n);
      chk("pwm_full", n, 256);

      // Asynchronous reset mid-AUTO with step button held
      sw = 2'b11;
      step(40);
      chk("pre_rst_nz", int'(rgb_code != 3'd0), 1);
      btn = 4'b0001;
      #3;
      rst_n = 1'b0;
      #1;
      chk("arst_code", rgb_code, 0);
      chk("arst_en", rgb_en, 1);
      chk("arst_state", state, 0);
      sw = 2'b00;
      step(3);
      rst_n = 1'b1;
      step(30);
      chk("held_no_pulse", rgb_code, 0);
      btn = 4'b0000;
      step(15);
      press_lat(4'b0001, 0, 1);

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

endmodule
